// File: rtl/cosim_commit_checker_if.sv
// cosim_commit_checker_if: DUT/reference commit streams, clear control and checker status.
interface cosim_commit_checker_if #(
  parameter int FifoDepth = 8,
  parameter int XregW = 64,
  parameter int FregW = 64,
  parameter int KeyW = 16
);
  localparam int CntW = $clog2(FifoDepth) + 1;
  logic dut_valid_i;
  logic dut_ready_o;
  logic [XregW-1:0] dut_pc_i;
  logic [KeyW-1:0] dut_key_i;
  logic [FregW-1:0] dut_value_i;
  logic ref_valid_i;
  logic ref_ready_o;
  logic [XregW-1:0] ref_pc_i;
  logic [KeyW-1:0] ref_key_i;
  logic [FregW-1:0] ref_value_i;
  logic clear_i;
  logic mismatch_o;
  logic halted_o;
  logic [CntW-1:0] fifo_count_o;
  logic [31:0] match_count_o;
  logic [XregW-1:0] err_pc_o;
  logic [KeyW-1:0] err_key_o;
  logic [FregW-1:0] err_exp_value_o;
  logic [FregW-1:0] err_act_value_o;
  modport master (
    output dut_valid_i, dut_pc_i, dut_key_i, dut_value_i,
    output ref_valid_i, ref_pc_i, ref_key_i, ref_value_i, clear_i,
    input dut_ready_o, ref_ready_o, mismatch_o, halted_o, fifo_count_o,
    input match_count_o, err_pc_o, err_key_o, err_exp_value_o, err_act_value_o
  );
  modport slave (
    input dut_valid_i, dut_pc_i, dut_key_i, dut_value_i,
    input ref_valid_i, ref_pc_i, ref_key_i, ref_value_i, clear_i,
    output dut_ready_o, ref_ready_o, mismatch_o, halted_o, fifo_count_o,
    output match_count_o, err_pc_o, err_key_o, err_exp_value_o, err_act_value_o
  );
endinterface

// File: rtl/cosim_commit_checker.sv
// cosim_commit_checker: buffers DUT register commits and compares them in order against reference records.
// Define COSIM_CHECKER_PC_CHECK_EN to also require matching PCs.
module cosim_commit_checker #(
  parameter int FifoDepth = 8,
  parameter int XregW = 64,
  parameter int FregW = 64,
  parameter int KeyW = 16
) (
  input logic clk_i,
  input logic rst_i,
  cosim_commit_checker_if.slave bus
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
`ifdef COSIM_CHECKER_PC_CHECK_EN
  localparam bit PcCheck = 1'b1;
`else
  localparam bit PcCheck = 1'b0;
`endif
  typedef enum logic {RUN, HALT} state_t;
  state_t state, next_state;
  logic [XregW-1:0] pc_mem [FifoDepth];
  logic [KeyW-1:0] key_mem [FifoDepth];
  logic [FregW-1:0] val_mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0] match_cnt;
  logic mismatch;
  logic [XregW-1:0] err_pc;
  logic [KeyW-1:0] err_key;
  logic [FregW-1:0] err_exp, err_act;
  logic dut_ready, ref_ready, push, cmp, match;
  // Readies come only from registered state; reset forces them low while asserted.
  assign dut_ready = !rst_i && state == RUN && count < CW'(FifoDepth);
  assign ref_ready = !rst_i && state == RUN && count != '0;
  assign push = bus.dut_valid_i && dut_ready;
  assign cmp = bus.ref_valid_i && ref_ready;
  assign match = key_mem[rd_ptr] == bus.ref_key_i && val_mem[rd_ptr] == bus.ref_value_i &&
                 (!PcCheck || pc_mem[rd_ptr] == bus.ref_pc_i);
  always_comb begin
    next_state = bus.clear_i ? RUN : (cmp && !match) ? HALT : state;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr] <= bus.dut_pc_i;
      key_mem[wr_ptr] <= bus.dut_key_i;
      val_mem[wr_ptr] <= bus.dut_value_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.clear_i) begin
      state <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      match_cnt <= '0;
      mismatch <= 1'b0;
      err_pc <= '0;
      err_key <= '0;
      err_exp <= '0;
      err_act <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (cmp) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(cmp);
      if (cmp && match && match_cnt != '1) match_cnt <= match_cnt + 32'd1;
      if (cmp && !match) begin
        mismatch <= 1'b1;
        err_pc <= pc_mem[rd_ptr];
        err_key <= key_mem[rd_ptr];
        err_exp <= bus.ref_value_i;
        err_act <= val_mem[rd_ptr];
      end
    end
  end
  assign bus.dut_ready_o = dut_ready;
  assign bus.ref_ready_o = ref_ready;
  assign bus.mismatch_o = mismatch;
  assign bus.halted_o = state == HALT;
  assign bus.fifo_count_o = count;
  assign bus.match_count_o = match_cnt;
  assign bus.err_pc_o = err_pc;
  assign bus.err_key_o = err_key;
  assign bus.err_exp_value_o = err_exp;
  assign bus.err_act_value_o = err_act;
endmodule
